// File: rtl/mario_draw_pkg.sv
// Shared constants and types for the Mario sprite draw path.
// Also used by sprite_hit_test so enemy/coin sprites can reuse the same geometry.
package mario_draw_pkg;

    localparam int SPR_W_DEF = 32;
    localparam int SPR_H_DEF = 32;
    localparam int RGB_W     = 12;
    localparam int SID_W     = 6;
    localparam int X_W       = 11;
    localparam int Y_W       = 10;

    localparam logic [RGB_W-1:0] TRANS_KEY_DEF = 12'hF0F;
    localparam logic [RGB_W-1:0] DEBUG_RGB     = 12'hFFF;
    localparam logic [SID_W-1:0] SID_RST       = 6'd32;

    // Per-frame latched sprite placement
    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [SID_W-1:0] id;
    } shadow_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational box test for one sprite: inside flag plus sprite-local lx/ly.
// The end bounds are computed one bit wider so a box near the right/bottom edge never wraps.
module sprite_hit_test
    import mario_draw_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF,
    localparam int LX_W = $clog2(SPR_W),
    localparam int LY_W = $clog2(SPR_H)
) (
    input  logic            pix_valid_i,
    input  logic [X_W-1:0]  pix_x_i,
    input  logic [Y_W-1:0]  pix_y_i,
    input  logic [X_W-1:0]  box_x_i,
    input  logic [Y_W-1:0]  box_y_i,
    output logic            inbox_o,
    output logic [LX_W-1:0] lx_o,
    output logic [LY_W-1:0] ly_o
);

    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;

    assign x_end = {1'b0, box_x_i} + (X_W+1)'(SPR_W);
    assign y_end = {1'b0, box_y_i} + (Y_W+1)'(SPR_H);

    always_comb begin
        inbox_o = pix_valid_i
               && (pix_x_i >= box_x_i) && ({1'b0, pix_x_i} < x_end)
               && (pix_y_i >= box_y_i) && ({1'b0, pix_y_i} < y_end);
    end

    assign lx_o = LX_W'(pix_x_i - box_x_i);
    assign ly_o = LY_W'(pix_y_i - box_y_i);

endmodule

// File: rtl/mario_sprite_draw.sv
// Mario sprite pixel generator: shadow placement regs, box test, sync-ROM fetch, output mux.
// Optional BBOX_DEBUG_EN paints the sprite bounding-box outline in DEBUG_RGB.
module mario_sprite_draw
    import mario_draw_pkg::*;
#(
    parameter int               SPR_W     = SPR_W_DEF,
    parameter int               SPR_H     = SPR_H_DEF,
    parameter int               ADDR_W    = 16,
    parameter logic [RGB_W-1:0] TRANS_KEY = TRANS_KEY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [X_W-1:0]    mario_x,
    input  logic [Y_W-1:0]    mario_y,
    input  logic [SID_W-1:0]  mario_id,
    input  logic              pix_valid,
    input  logic [X_W-1:0]    pix_x,
    input  logic [Y_W-1:0]    pix_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [RGB_W-1:0]  rom_data,
    output logic              spr_valid,
    output logic              spr_hit,
    output logic [RGB_W-1:0]  spr_rgb
);

    localparam int LX_W   = $clog2(SPR_W);
    localparam int LY_W   = $clog2(SPR_H);
    localparam int IDX_W  = SID_W + LY_W + LX_W;
    localparam int STAGES = 2;

    shadow_t           shadow_q, shadow_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [STAGES:1]   vld_pipe_q;
    logic [STAGES:1]   hit_pipe_q;
    logic              spr_valid_q;
    logic              spr_hit_q, spr_hit_d;
    logic [RGB_W-1:0]  spr_rgb_q, spr_rgb_d;

    logic              inbox;
    logic [LX_W-1:0]   lx;
    logic [LY_W-1:0]   ly;
    logic [IDX_W-1:0]  rom_idx;

    // Placement only changes at frame_start, so the sprite cannot tear mid-frame
    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) begin
            shadow_d = '{x: mario_x, y: mario_y, id: mario_id};
        end
    end

    sprite_hit_test #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_hit (
        .pix_valid_i (pix_valid),
        .pix_x_i     (pix_x),
        .pix_y_i     (pix_y),
        .box_x_i     (shadow_q.x),
        .box_y_i     (shadow_q.y),
        .inbox_o     (inbox),
        .lx_o        (lx),
        .ly_o        (ly)
    );

    assign rom_idx = {shadow_q.id, ly, lx};

    // Hold the address outside the box to avoid pointless ROM toggling
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (inbox) begin
            rom_addr_d = ADDR_W'(rom_idx);
        end
    end

`ifdef BBOX_DEBUG_EN
    logic            on_edge;
    logic [STAGES:1] edge_pipe_q;

    // SPR_W/SPR_H are powers of two, so all-ones is the last column/row
    assign on_edge = inbox && (lx == '0 || lx == '1 || ly == '0 || ly == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_pipe_q <= '0;
        end else begin
            edge_pipe_q <= {edge_pipe_q[STAGES-1:1], on_edge};
        end
    end

    always_comb begin
        spr_hit_d = hit_pipe_q[STAGES] && (edge_pipe_q[STAGES] || (rom_data != TRANS_KEY));
        spr_rgb_d = '0;
        if (edge_pipe_q[STAGES]) begin
            spr_rgb_d = DEBUG_RGB;
        end else if (spr_hit_d) begin
            spr_rgb_d = rom_data;
        end
    end
`else
    always_comb begin
        spr_hit_d = hit_pipe_q[STAGES] && (rom_data != TRANS_KEY);
        spr_rgb_d = spr_hit_d ? rom_data : '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '{x: '0, y: '0, id: SID_RST};
            rom_addr_q  <= '0;
            vld_pipe_q  <= '0;
            hit_pipe_q  <= '0;
            spr_valid_q <= 1'b0;
            spr_hit_q   <= 1'b0;
            spr_rgb_q   <= '0;
        end else begin
            shadow_q    <= shadow_d;
            rom_addr_q  <= rom_addr_d;
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:1], pix_valid};
            hit_pipe_q  <= {hit_pipe_q[STAGES-1:1], inbox};
            spr_valid_q <= vld_pipe_q[STAGES];
            spr_hit_q   <= spr_hit_d;
            spr_rgb_q   <= spr_rgb_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign spr_valid = spr_valid_q;
    assign spr_hit   = spr_hit_q;
    assign spr_rgb   = spr_rgb_q;

endmodule

// File: tb/tb_mario_sprite_draw.sv
// Directed bench for mario_sprite_draw with a synchronous ROM model.
// Expected outputs follow the BBOX_DEBUG_EN setting of the build.
module tb_mario_sprite_draw;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [10:0] mario_x;
    logic [9:0]  mario_y;
    logic [5:0]  mario_id;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [15:0] rom_addr;
    logic [11:0] rom_data;
    logic        spr_valid;
    logic        spr_hit;
    logic [11:0] spr_rgb;

    int errors = 0;
    int checks = 0;

`ifdef BBOX_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    always #5 clk = ~clk;

    mario_sprite_draw dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .mario_x     (mario_x),
        .mario_y     (mario_y),
        .mario_id    (mario_id),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .spr_valid   (spr_valid),
        .spr_hit     (spr_hit),
        .spr_rgb     (spr_rgb)
    );

    // Sync ROM: pattern never equals F0F (top nibble 4..7) unless forced
    logic        rom_force_en;
    logic [11:0] rom_force;
    always @(posedge clk) rom_data <= rom_force_en ? rom_force : {2'b01, rom_addr[9:0]};

    function automatic logic [11:0] pat(int lx, int ly);
        return {2'b01, 5'(ly), 5'(lx)};
    endfunction

    // {hit, rgb} expected for a valid pixel
    function automatic logic [12:0] exp_out(bit inbox, int lx, int ly, logic [11:0] data);
        if (!inbox) return 13'h0;
        if (DBG && (lx == 0 || lx == 31 || ly == 0 || ly == 31)) return {1'b1, 12'hFFF};
        if (data == 12'hF0F) return 13'h0;
        return {1'b1, data};
    endfunction

    task automatic latch_frame(input int x, input int y, input int id);
        mario_x = 11'(x); mario_y = 10'(y); mario_id = 6'(id);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Called just after a negedge; returns rom_addr one edge later and spr_* two edges later
    task automatic run_pixel(input int x, input int y, input bit v, output logic [15:0] addr,
                             output logic vld, output logic hit, output logic [11:0] rgb);
        pix_x = 11'(x); pix_y = 10'(y); pix_valid = v;
        @(negedge clk);
        addr = rom_addr;
        pix_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vld = spr_valid; hit = spr_hit; rgb = spr_rgb;
    endtask

    task automatic test_reset();
        logic [15:0] a; logic v, h; logic [11:0] c;
        rst = 1'b1; frame_start = 1'b0; mario_x = '0; mario_y = '0; mario_id = '0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; rom_force_en = 1'b0; rom_force = '0;
        repeat (2) @(negedge clk);
        checks++; if ({rom_addr, spr_valid, spr_hit, spr_rgb} !== 30'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {rom_addr, spr_valid, spr_hit, spr_rgb});
        end
        rst = 1'b0;
        @(negedge clk);
        run_pixel(128, 704, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0 || a !== 16'h0) begin
            errors++; $display("FAIL reset_no_hit_128_704: got hit=%b addr=%h want hit=0 addr=0000", h, a);
        end
        run_pixel(5, 5, 1'b1, a, v, h, c);
        checks++; if (a !== 16'h80A5) begin
            errors++; $display("FAIL reset_default_addr: got %h want 80a5", a);
        end
        checks++; if ({h, c} !== exp_out(1, 5, 5, pat(5, 5))) begin
            errors++; $display("FAIL reset_default_hit: got %h want %h", {h, c}, exp_out(1, 5, 5, pat(5, 5)));
        end
        // Stream a hitting pixel, then reset asynchronously between edges
        pix_x = 11'd5; pix_y = 10'd5; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (spr_hit !== 1'b1) begin
            errors++; $display("FAIL pre_async_hit: got %b want 1", spr_hit);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({rom_addr, spr_valid, spr_hit, spr_rgb} !== 30'h0) begin
            errors++; $display("FAIL async_reset: got %h want 0", {rom_addr, spr_valid, spr_hit, spr_rgb});
        end
        @(negedge clk);
        pix_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame_latch();
        logic [15:0] a; logic v, h; logic [11:0] c;
        latch_frame(128, 704, 32);
        rom_force_en = 1'b1; rom_force = 12'h0A0;
        run_pixel(128, 704, 1'b1, a, v, h, c);
        checks++; if (a !== 16'h8000) begin
            errors++; $display("FAIL latch_addr: got %h want 8000", a);
        end
        checks++; if (v !== 1'b1 || {h, c} !== exp_out(1, 0, 0, 12'h0A0)) begin
            errors++; $display("FAIL latch_hit: got v=%b %h want v=1 %h", v, {h, c}, exp_out(1, 0, 0, 12'h0A0));
        end
    endtask

    task automatic test_transparency();
        logic [15:0] a; logic v, h; logic [11:0] c;
        rom_force_en = 1'b1; rom_force = 12'hF0F;
        run_pixel(140, 710, 1'b1, a, v, h, c);
        checks++; if ({h, c} !== 13'h0 || a !== 16'h80CC) begin
            errors++; $display("FAIL transparent: got %h addr=%h want 0000 addr=80cc", {h, c}, a);
        end
        rom_force_en = 1'b0;
        run_pixel(160, 704, 1'b1, a, v, h, c);
        checks++; if (v !== 1'b1 || {h, c} !== 13'h0) begin
            errors++; $display("FAIL right_outside: got v=%b %h want v=1 0000", v, {h, c});
        end
        checks++; if (a !== 16'h80CC) begin
            errors++; $display("FAIL addr_hold: got %h want 80cc", a);
        end
        run_pixel(159, 735, 1'b1, a, v, h, c);
        checks++; if (a !== 16'h83FF) begin
            errors++; $display("FAIL corner_addr: got %h want 83ff", a);
        end
        checks++; if ({h, c} !== exp_out(1, 31, 31, pat(31, 31))) begin
            errors++; $display("FAIL corner_hit: got %h want %h", {h, c}, exp_out(1, 31, 31, pat(31, 31)));
        end
        run_pixel(135, 712, 1'b0, a, v, h, c);
        checks++; if (v !== 1'b0 || h !== 1'b0 || a !== 16'h83FF) begin
            errors++; $display("FAIL invalid_pixel: got v=%b h=%b addr=%h want 0 0 83ff", v, h, a);
        end
        run_pixel(127, 704, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0) begin
            errors++; $display("FAIL left_outside: got %b want 0", h);
        end
        run_pixel(128, 736, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0) begin
            errors++; $display("FAIL below_outside: got %b want 0", h);
        end
    endtask

    task automatic test_pixel_stream();
        int hits = 0;
        rom_force_en = 1'b0;
        for (int j = 0; j < 43; j++) begin
            if (j >= 3) begin
                int x = 120 + j - 3;
                bit inb = (x >= 128 && x < 160);
                logic [12:0] e = exp_out(inb, x - 128, 6, pat(x - 128, 6));
                checks++; if (spr_valid !== 1'b1 || {spr_hit, spr_rgb} !== e) begin
                    errors++; $display("FAIL stream_x%0d: got v=%b %h want v=1 %h", x, spr_valid, {spr_hit, spr_rgb}, e);
                end
                if (spr_valid && spr_hit) hits++;
            end
            if (j < 40) begin
                pix_x = 11'(120 + j); pix_y = 10'd710; pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (hits !== 32) begin
            errors++; $display("FAIL stream_hit_count: got %0d want 32", hits);
        end
        // Valid gap in the middle of the row
        for (int j = 0; j < 6; j++) begin
            if (j >= 3) begin
                bit ve = (j - 3 != 1);
                checks++; if (spr_valid !== ve || spr_hit !== ve) begin
                    errors++; $display("FAIL gap_slot%0d: got v=%b h=%b want %b", j - 3, spr_valid, spr_hit, ve);
                end
            end
            if (j < 3) begin
                pix_x = 11'(130 + j); pix_y = 10'd710; pix_valid = (j != 1);
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_tearing();
        logic [15:0] a; logic v, h; logic [11:0] c;
        mario_x = 11'd144;
        run_pixel(128, 710, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b1) begin
            errors++; $display("FAIL notear_old_start: got %b want 1", h);
        end
        run_pixel(127, 710, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0) begin
            errors++; $display("FAIL notear_before_old: got %b want 0", h);
        end
        // frame_start in the same cycle as an in-box pixel: pixel uses old placement
        mario_x = 11'd144; mario_y = 10'd704; mario_id = 6'd47; frame_start = 1'b1;
        pix_x = 11'd128; pix_y = 10'd710; pix_valid = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; pix_valid = 1'b0;
        checks++; if (rom_addr !== 16'h80C0) begin
            errors++; $display("FAIL coincident_addr: got %h want 80c0", rom_addr);
        end
        repeat (2) @(negedge clk);
        checks++; if ({spr_hit, spr_rgb} !== exp_out(1, 0, 6, pat(0, 6))) begin
            errors++; $display("FAIL coincident_hit: got %h want %h", {spr_hit, spr_rgb}, exp_out(1, 0, 6, pat(0, 6)));
        end
        run_pixel(143, 710, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0) begin
            errors++; $display("FAIL notear_new_before: got %b want 0", h);
        end
        run_pixel(144, 710, 1'b1, a, v, h, c);
        checks++; if (a !== 16'hBCC0 || {h, c} !== exp_out(1, 0, 6, pat(0, 6))) begin
            errors++; $display("FAIL notear_new_start: got addr=%h %h want bcc0 %h", a, {h, c}, exp_out(1, 0, 6, pat(0, 6)));
        end
    endtask

    task automatic test_screen_edge();
        logic [15:0] a; logic v, h; logic [11:0] c;
        latch_frame(2040, 704, 32);
        run_pixel(2047, 704, 1'b1, a, v, h, c);
        checks++; if (a !== 16'h8007 || {h, c} !== exp_out(1, 7, 0, pat(7, 0))) begin
            errors++; $display("FAIL edge_last_col: got addr=%h %h want 8007 %h", a, {h, c}, exp_out(1, 7, 0, pat(7, 0)));
        end
        run_pixel(0, 704, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0) begin
            errors++; $display("FAIL edge_no_wrap: got %b want 0", h);
        end
        run_pixel(2039, 704, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0) begin
            errors++; $display("FAIL edge_left_of_box: got %b want 0", h);
        end
    endtask

    task automatic test_bbox();
        logic [15:0] a; logic v, h; logic [11:0] c;
        latch_frame(128, 704, 32);
        rom_force_en = 1'b1; rom_force = 12'hF0F;
        run_pixel(128, 720, 1'b1, a, v, h, c);
        checks++; if ({h, c} !== exp_out(1, 0, 16, 12'hF0F)) begin
            errors++; $display("FAIL bbox_edge: got %h want %h", {h, c}, exp_out(1, 0, 16, 12'hF0F));
        end
        rom_force_en = 1'b0;
    endtask

    task automatic test_midframe_reset();
        logic [15:0] a; logic v, h; logic [11:0] c;
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_pixel(128, 704, 1'b1, a, v, h, c);
        checks++; if (h !== 1'b0) begin
            errors++; $display("FAIL midreset_old_pos: got %b want 0", h);
        end
        run_pixel(0, 0, 1'b1, a, v, h, c);
        checks++; if (a !== 16'h8000 || {h, c} !== exp_out(1, 0, 0, pat(0, 0))) begin
            errors++; $display("FAIL midreset_default: got addr=%h %h want 8000 %h", a, {h, c}, exp_out(1, 0, 0, pat(0, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_frame_latch();
        test_transparency();
        test_pixel_stream();
        test_no_tearing();
        test_screen_edge();
        test_bbox();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
